fifo_ram_ctrl: RTL and testbench

- Initiator side of the team's simple dual-port RAM: the 1-cycle registered-read RAM is external to this block.
- The block owns the write/read pointers and drives the RAM write port (we/wa/wd) and read address (ra).
- It consumes RAM read data one cycle after issuing the address and presents a first-word-fall-through valid/ready read interface.
- A 2-entry output buffer (head + skid) hides the RAM read latency, so it sustains 1 word/cycle in and out.

---
 rtl/fifo_ram_ctrl.sv | 112 +++++++++++
 tb/tb_fifo_ram_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_ram_ctrl.sv
// FIFO controller driving an external 1-cycle registered-read dual-port RAM.
// A head/skid output buffer hides the read latency for 1 word/cycle FWFT.
module fifo_ram_ctrl #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 4,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DWIDTH-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DWIDTH-1:0] rd_data,
  output logic [AWIDTH+1:0] count,
  output logic              mem_we,
  output logic [AWIDTH-1:0] mem_wa,
  output logic [DWIDTH-1:0] mem_wd,
  output logic [AWIDTH-1:0] mem_ra,
  input  logic [DWIDTH-1:0] mem_rd
);

  localparam int PW = AWIDTH + 1;
  localparam int CW = AWIDTH + 2;

  logic [AWIDTH:0]   r_wr_ptr;
  logic [AWIDTH:0]   r_rd_ptr;
  logic              r_pend;
  logic              r_head_v;
  logic              r_skid_v;
  logic [DWIDTH-1:0] r_head;
  logic [DWIDTH-1:0] r_skid;

  logic [AWIDTH:0]   w_ram_cnt;
  logic              w_push;
  logic              w_pop;
  logic              w_fetch;
  logic [1:0]        w_buf_next;
  logic              w_head_v_n;
  logic              w_skid_v_n;
  logic [DWIDTH-1:0] w_head_n;
  logic [DWIDTH-1:0] w_skid_n;

  assign w_ram_cnt = r_wr_ptr - r_rd_ptr;

  assign wr_ready = rst_n & (w_ram_cnt != PW'(DEPTH));
  assign w_push   = wr_valid & wr_ready;
  assign mem_we   = w_push;
  assign mem_wa   = r_wr_ptr[AWIDTH-1:0];
  assign mem_wd   = wr_data;
  assign mem_ra   = r_rd_ptr[AWIDTH-1:0];

  assign rd_valid = r_head_v;
  assign rd_data  = r_head;
  assign w_pop    = r_head_v & rd_ready;

  // Occupancy the buffer will have once this cycle's pop and landing settle.
  assign w_buf_next = {1'b0, r_head_v} + {1'b0, r_skid_v}
                    + {1'b0, r_pend} - {1'b0, w_pop};
  assign w_fetch = (w_ram_cnt != '0) & (w_buf_next < 2'd2);

  assign count = CW'(w_ram_cnt) + CW'(r_pend)
               + CW'(r_head_v) + CW'(r_skid_v);

  always_comb begin
    w_head_v_n = r_head_v;
    w_skid_v_n = r_skid_v;
    w_head_n   = r_head;
    w_skid_n   = r_skid;
    if (w_pop) begin
      if (r_skid_v) begin
        w_head_n   = r_skid;
        w_skid_v_n = 1'b0;
      end else begin
        w_head_v_n = 1'b0;
      end
    end
    if (r_pend) begin
      if (!w_head_v_n) begin
        w_head_n   = mem_rd;
        w_head_v_n = 1'b1;
      end else begin
        w_skid_n   = mem_rd;
        w_skid_v_n = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_pend   <= 1'b0;
      r_head_v <= 1'b0;
      r_skid_v <= 1'b0;
      r_head   <= '0;
      r_skid   <= '0;
    end else begin
      if (w_push)
        r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_fetch)
        r_rd_ptr <= r_rd_ptr + 1'b1;
      r_pend   <= w_fetch;
      r_head_v <= w_head_v_n;
      r_skid_v <= w_skid_v_n;
      r_head   <= w_head_n;
      r_skid   <= w_skid_n;
    end
  end

endmodule

// File: tb/tb_fifo_ram_ctrl.sv
// Bench for fifo_ram_ctrl with a behavioural 1-cycle registered-read RAM.
// Vector table for reset/single word, then fill, stream, random, reset.
module tb_fifo_ram_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_valid;
  logic        wr_ready;
  logic [15:0] wr_data;
  logic        rd_valid;
  logic        rd_ready;
  logic [15:0] rd_data;
  logic [5:0]  count;
  logic        mem_we;
  logic [3:0]  mem_wa;
  logic [15:0] mem_wd;
  logic [3:0]  mem_ra;
  logic [15:0] mem_rd;

  logic [15:0] ram [16];

  int n_chk  = 0;
  int n_fail = 0;

  fifo_ram_ctrl #(.DWIDTH(16), .AWIDTH(4), .DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .count(count),
    .mem_we(mem_we), .mem_wa(mem_wa), .mem_wd(mem_wd),
    .mem_ra(mem_ra), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) ram[mem_wa] <= mem_wd;
    mem_rd <= ram[mem_ra];
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        rst_n;
    logic        wv;
    logic [15:0] wd;
    logic        rr;
    logic        e_wrdy;
    logic        e_we;
    logic [3:0]  e_wa;
    logic [3:0]  e_ra;
    logic        e_rv;
    logic [15:0] e_rd;
    logic [5:0]  e_cnt;
  } vec_t;

  vec_t vt [9];
  logic [15:0] q [$];

  initial begin
    int n, got, first, last, pops, wseq, mr;
    logic prev_push;
    logic [3:0] prev_ra;
    logic [15:0] e;

    rst_n = 1'b0; wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;

    vt[0] = '{1'b0, 1'b1, 16'h1111, 1'b0,
              1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 16'h0000, 6'd0};
    vt[1] = '{1'b0, 1'b1, 16'h2222, 1'b0,
              1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 16'h0000, 6'd0};
    vt[2] = '{1'b1, 1'b0, 16'h0000, 1'b0,
              1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 16'h0000, 6'd0};
    vt[3] = '{1'b1, 1'b1, 16'hA5A5, 1'b0,
              1'b1, 1'b1, 4'd0, 4'd0, 1'b0, 16'h0000, 6'd0};
    vt[4] = '{1'b1, 1'b0, 16'h0000, 1'b0,
              1'b1, 1'b0, 4'd1, 4'd0, 1'b0, 16'h0000, 6'd1};
    vt[5] = '{1'b1, 1'b0, 16'h0000, 1'b0,
              1'b1, 1'b0, 4'd1, 4'd1, 1'b0, 16'h0000, 6'd1};
    vt[6] = '{1'b1, 1'b0, 16'h0000, 1'b0,
              1'b1, 1'b0, 4'd1, 4'd1, 1'b1, 16'hA5A5, 6'd1};
    vt[7] = '{1'b1, 1'b0, 16'h0000, 1'b1,
              1'b1, 1'b0, 4'd1, 4'd1, 1'b1, 16'hA5A5, 6'd1};
    vt[8] = '{1'b1, 1'b0, 16'h0000, 1'b0,
              1'b1, 1'b0, 4'd1, 4'd1, 1'b0, 16'h0000, 6'd0};

    @(posedge clk);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      rst_n    = vt[i].rst_n;
      wr_valid = vt[i].wv;
      wr_data  = vt[i].wd;
      rd_ready = vt[i].rr;
      #1;
      chk($sformatf("v%0d_wr_ready", i), wr_ready, vt[i].e_wrdy);
      chk($sformatf("v%0d_mem_we", i), mem_we, vt[i].e_we);
      chk($sformatf("v%0d_mem_wa", i), mem_wa, vt[i].e_wa);
      chk($sformatf("v%0d_mem_ra", i), mem_ra, vt[i].e_ra);
      chk($sformatf("v%0d_rd_valid", i), rd_valid, vt[i].e_rv);
      chk($sformatf("v%0d_count", i), count, vt[i].e_cnt);
      if (vt[i].e_rv)
        chk($sformatf("v%0d_rd_data", i), rd_data, vt[i].e_rd);
    end

    // Fill: 16 in RAM plus head and skid.
    @(negedge clk);
    rd_ready = 1'b0; wr_valid = 1'b1; n = 0;
    for (int c = 0; c < 40; c++) begin
      wr_data = 16'(n);
      #1;
      if (!wr_ready) break;
      n++;
      @(negedge clk);
    end
    chk("fill_accepted", n, 18);
    chk("fill_count", count, 18);
    chk("fill_mem_we_off", mem_we, 1'b0);

    wr_valid = 1'b0; rd_ready = 1'b1;
    got = 0; first = -1; last = 0;
    for (int c = 0; c < 60 && got < 18; c++) begin
      if (c > 0) begin @(negedge clk); #1; end
      if (rd_valid) begin
        chk("drain_data", rd_data, 16'(got));
        if (first < 0) first = c;
        last = c;
        got++;
      end
    end
    chk("drain_words", got, 18);
    chk("drain_back_to_back", last - first, 17);
    @(negedge clk); #1;
    chk("drain_count", count, 0);
    chk("drain_rd_valid", rd_valid, 1'b0);

    // Streaming at full rate.
    @(negedge clk);
    wr_valid = 1'b1; rd_ready = 1'b1; wseq = 16'h0100; pops = 0;
    for (int c = 0; c < 100; c++) begin
      wr_data = 16'(wseq);
      #1;
      if (rd_valid) begin
        pops++;
        if (q.size() == 0) chk("stream_underflow", 1, 0);
        else chk("stream_data", rd_data, q.pop_front());
      end
      if (wr_ready) begin q.push_back(16'(wseq)); wseq++; end
      if (c >= 3) chk("stream_count_2or3",
                      (count == 6'd2 || count == 6'd3), 1'b1);
      @(negedge clk);
    end
    chk("stream_pops", pops, 97);
    wr_valid = 1'b0;
    for (int c = 0; c < 20 && q.size() > 0; c++) begin
      #1;
      if (rd_valid) chk("stream_tail", rd_data, q.pop_front());
      @(negedge clk);
    end
    #1;
    chk("stream_left", q.size(), 0);
    chk("stream_end_count", count, 0);

    // Random traffic with observational RAM-occupancy model.
    mr = 0; prev_push = 1'b0; prev_ra = mem_ra;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (c < 300) begin
        wr_valid = ($urandom_range(0, 99) < 80);
        rd_ready = ($urandom_range(0, 99) < 25);
      end else if (c < 700) begin
        wr_valid = ($urandom_range(0, 99) < 60);
        rd_ready = ($urandom_range(0, 99) < 60);
      end else begin
        wr_valid = ($urandom_range(0, 99) < 30);
        rd_ready = ($urandom_range(0, 99) < 90);
      end
      wr_data = 16'($urandom);
      #1;
      if (prev_push) mr++;
      if (mem_ra != prev_ra) mr--;
      prev_ra = mem_ra;
      chk("rand_wr_ready", wr_ready, (mr != 16));
      chk("rand_count", count, 6'(q.size()));
      if (rd_valid && rd_ready) begin
        if (q.size() == 0) chk("rand_underflow", 1, 0);
        else chk("rand_data", rd_data, q.pop_front());
      end
      if (wr_valid && wr_ready) q.push_back(wr_data);
      prev_push = wr_valid && wr_ready;
    end

    // Reset mid-stream with a fetch in flight.
    @(negedge clk);
    rst_n = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0;
    q.delete();
    @(negedge clk);
    rst_n = 1'b1; wr_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wr_data = 16'h0A00 + 16'(i);
      @(negedge clk);
    end
    wr_valid = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    chk("pre_rst_count", count, 10);
    wr_valid = 1'b1; rd_ready = 1'b1; wr_data = 16'h0BBB;
    @(negedge clk); #1;
    chk("pre_rst_count_pend", count, 10);
    rst_n = 1'b0; wr_valid = 1'b1; rd_ready = 1'b0;
    #1;
    chk("rst_wr_ready_gated", wr_ready, 1'b0);
    chk("rst_mem_we_gated", mem_we, 1'b0);
    @(negedge clk);
    rst_n = 1'b1; wr_valid = 1'b0;
    #1;
    chk("post_rst_count", count, 0);
    chk("post_rst_rd_valid", rd_valid, 1'b0);
    @(negedge clk);
    wr_valid = 1'b1; wr_data = 16'h1234;
    #1;
    chk("post_rst_no_glitch", rd_valid, 1'b0);
    chk("post_rst_wr_ready", wr_ready, 1'b1);
    @(negedge clk);
    wr_valid = 1'b0; rd_ready = 1'b1;
    got = 0; e = 16'h0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (rd_valid) begin got = 1; e = rd_data; break; end
      @(negedge clk);
    end
    chk("post_rst_seen", got, 1);
    chk("post_rst_first_word", e, 16'h1234);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
